uart_rx_ctrl: RTL and testbench

Receive-side controller between the UART receiver and the AXI4-Lite register block. It accepts one-cycle byte strobes from the receiver, buffers them in a show-ahead FIFO, and tracks overrun and receive idle timeout. It raises a single level interrupt for threshold, timeout and overrun. Software drains bytes through a pop interface driven by the register block.

---
 rtl/uart_rx_ctrl.sv | 171 +++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: show-ahead byte FIFO, overrun and idle timeout
// flags, and one registered level interrupt for the register block.
//
// Ports:
//   clk, rst_n       clock, async active-low reset
//   rx_data/valid    byte strobe from the receiver
//   enable           gate for incoming bytes
//   flush            empty the FIFO, clear timeout
//   rd_en            pop request; rd_data is the head byte
//   rd_empty/full    occupancy status
//   level            occupancy 0..DEPTH
//   thresh           level interrupt threshold (0 = off)
//   irq_en           [0] level, [1] timeout, [2] overrun
//   ovr_clr          clear overrun
//   overrun/timeout  sticky status flags
//   irq              registered interrupt
module uart_rx_ctrl #(
  parameter int CLOCK_FREQ    = 50000000,
  parameter int BAUD_RATE     = 9600,
  parameter int DEPTH         = 16,
  parameter int TIMEOUT_CHARS = 4,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  input  logic          enable,
  input  logic          flush,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          rd_empty,
  output logic          rd_full,
  output logic [LW-1:0] level,
  input  logic [LW-1:0] thresh,
  input  logic [2:0]    irq_en,
  input  logic          ovr_clr,
  output logic          overrun,
  output logic          timeout,
  output logic          irq
);

  localparam int PW      = $clog2(DEPTH);
  localparam int CPB     = CLOCK_FREQ / BAUD_RATE;
  localparam int TO_CLKS = TIMEOUT_CHARS * 10 * CPB;
  localparam int TW      = $clog2(TO_CLKS + 1);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    EXPIRED
  } state_t;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          ovr_set;
  logic          act;
  logic [LW-1:0] lvl_nxt;
  state_t        state;
  logic [TW-1:0] cnt;

  always_comb begin
    pop     = rd_en & !rd_empty;
    push    = rx_valid & enable & (!rd_full | pop);
    ovr_set = rx_valid & enable & rd_full & !pop;
    act     = push | pop;
    lvl_nxt = level;
    if (flush)
      lvl_nxt = '0;
    else if (push & !pop)
      lvl_nxt = level + 1'b1;
    else if (pop & !push)
      lvl_nxt = level - 1'b1;
  end

  // Head byte is masked while empty so reset reads as zero.
  assign rd_data = rd_empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push & !flush)
      mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rd_empty <= 1'b1;
      rd_full  <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      level    <= lvl_nxt;
      rd_empty <= (lvl_nxt == '0);
      rd_full  <= (lvl_nxt == LW'(DEPTH));
    end
  end

  // Set beats clear when both land together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overrun <= 1'b0;
    else if (ovr_set)
      overrun <= 1'b1;
    else if (ovr_clr)
      overrun <= 1'b0;
  end

  // Transitions use the post-edge level so the count starts on the
  // same edge as the push that made the FIFO non-empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (lvl_nxt != '0)
            state <= COUNT;
        end
        COUNT: begin
          if (flush || lvl_nxt == '0) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (act) begin
            cnt <= '0;
          end else if (cnt == TW'(TO_CLKS - 1)) begin
            state   <= EXPIRED;
            timeout <= 1'b1;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        EXPIRED: begin
          if (flush || act) begin
            timeout <= 1'b0;
            cnt     <= '0;
            state   <= (lvl_nxt == '0) ? IDLE : COUNT;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          timeout <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      irq <= 1'b0;
    else
      irq <= (irq_en[0] & (thresh != '0) & (level >= thresh))
           | (irq_en[1] & timeout)
           | (irq_en[2] & overrun);
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: DEPTH 4, 100-cycle idle timeout.
// Each check is an immediate assertion against a hand-computed value.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       enable;
  logic       flush;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_empty;
  logic       rd_full;
  logic [2:0] level;
  logic [2:0] thresh;
  logic [2:0] irq_en;
  logic       ovr_clr;
  logic       overrun;
  logic       timeout;
  logic       irq;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  uart_rx_ctrl #(
    .CLOCK_FREQ   (1000000),
    .BAUD_RATE    (100000),
    .DEPTH        (4),
    .TIMEOUT_CHARS(1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .enable  (enable),
    .flush   (flush),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .rd_empty(rd_empty),
    .rd_full (rd_full),
    .level   (level),
    .thresh  (thresh),
    .irq_en  (irq_en),
    .ovr_clr (ovr_clr),
    .overrun (overrun),
    .timeout (timeout),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pop_byte();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    enable   = 1'b1;
    flush    = 1'b0;
    rd_en    = 1'b0;
    thresh   = 3'd2;
    irq_en   = 3'b001;
    ovr_clr  = 1'b0;
    tick();
    tick();
    chk("rst_level", level, 0);
    chk("rst_empty", rd_empty, 1);
    chk("rst_full", rd_full, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_to", timeout, 0);
    chk("rst_irq", irq, 0);
    chk("rst_data", rd_data, 8'h00);
    rst_n = 1'b1;
    tick();

    // threshold interrupt
    push_byte(8'hA5);
    push_byte(8'h3C);
    chk("th_level", level, 2);
    chk("th_irq_lat", irq, 0);
    chk("th_head", rd_data, 8'hA5);
    tick();
    chk("th_irq", irq, 1);
    pop_byte();
    chk("th_pop_data", rd_data, 8'h3C);
    chk("th_pop_level", level, 1);
    chk("th_irq_hold", irq, 1);
    tick();
    chk("th_irq_drop", irq, 0);
    pop_byte();
    chk("th_drained", rd_empty, 1);

    // full and overrun
    thresh = 3'd0;
    irq_en = 3'b000;
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    push_byte(8'h04);
    push_byte(8'h05);
    chk("ov_level", level, 4);
    chk("ov_full", rd_full, 1);
    chk("ov_flag", overrun, 1);
    chk("ov_d0", rd_data, 8'h01);
    pop_byte();
    chk("ov_d1", rd_data, 8'h02);
    pop_byte();
    chk("ov_d2", rd_data, 8'h03);
    pop_byte();
    chk("ov_d3", rd_data, 8'h04);
    pop_byte();
    chk("ov_empty", rd_empty, 1);
    chk("ov_sticky", overrun, 1);
    push_byte(8'h10);
    push_byte(8'h11);
    push_byte(8'h12);
    push_byte(8'h13);
    rx_data  = 8'h14;
    rx_valid = 1'b1;
    ovr_clr  = 1'b1;
    tick();
    rx_valid = 1'b0;
    chk("ov_set_wins", overrun, 1);
    tick();
    ovr_clr = 1'b0;
    chk("ov_clr", overrun, 0);
    chk("ov2_d0", rd_data, 8'h10);
    pop_byte();
    pop_byte();
    pop_byte();
    chk("ov2_d3", rd_data, 8'h13);
    pop_byte();
    chk("ov2_empty", rd_empty, 1);

    // simultaneous push and pop while full
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    push_byte(8'h04);
    rx_data  = 8'h05;
    rx_valid = 1'b1;
    rd_en    = 1'b1;
    tick();
    rx_valid = 1'b0;
    rd_en    = 1'b0;
    chk("pp_level", level, 4);
    chk("pp_full", rd_full, 1);
    chk("pp_ovr", overrun, 0);
    chk("pp_d0", rd_data, 8'h02);
    pop_byte();
    chk("pp_d1", rd_data, 8'h03);
    pop_byte();
    chk("pp_d2", rd_data, 8'h04);
    pop_byte();
    chk("pp_d3", rd_data, 8'h05);
    pop_byte();
    chk("pp_empty", rd_empty, 1);

    // idle timeout: 100 cycles after the push
    irq_en = 3'b010;
    push_byte(8'h5A);
    repeat (99) tick();
    chk("to_early", timeout, 0);
    tick();
    chk("to_set", timeout, 1);
    chk("to_irq_lat", irq, 0);
    tick();
    chk("to_irq", irq, 1);
    pop_byte();
    chk("to_clr", timeout, 0);
    chk("to_level", level, 0);
    tick();
    chk("to_irq_drop", irq, 0);

    // flush beats a same-cycle push; disabled bytes vanish
    irq_en = 3'b000;
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    chk("fl_pre", level, 3);
    rx_data  = 8'h44;
    rx_valid = 1'b1;
    flush    = 1'b1;
    tick();
    rx_valid = 1'b0;
    flush    = 1'b0;
    chk("fl_level", level, 0);
    chk("fl_empty", rd_empty, 1);
    enable = 1'b0;
    push_byte(8'h66);
    enable = 1'b1;
    chk("en_level", level, 0);
    chk("en_ovr", overrun, 0);
    push_byte(8'h55);
    chk("fl_next_head", rd_data, 8'h55);
    pop_byte();

    // asynchronous reset in mid-count
    thresh = 3'd2;
    irq_en = 3'b001;
    push_byte(8'hAA);
    push_byte(8'hBB);
    push_byte(8'hCC);
    repeat (50) tick();
    chk("ar_pre_irq", irq, 1);
    chk("ar_pre_lvl", level, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_level", level, 0);
    chk("ar_empty", rd_empty, 1);
    chk("ar_full", rd_full, 0);
    chk("ar_irq", irq, 0);
    chk("ar_to", timeout, 0);
    chk("ar_ovr", overrun, 0);
    chk("ar_data", rd_data, 8'h00);
    #3;
    rst_n = 1'b1;
    tick();
    push_byte(8'h7E);
    chk("ar_push_data", rd_data, 8'h7E);
    chk("ar_push_lvl", level, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
